// File: rtl/luhn_pkg.sv
// Shared definitions for the Luhn mod-16 framer, checker and benches.
// Holds the interface widths, the framer state encoding and a nibble select helper.
package luhn_pkg;

    localparam int SIZE_W = 8;
    localparam int NIB_W  = 4;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        DRAIN     = 2'd1,
        SEND_SIZE = 2'd2,
        SEND_DATA = 2'd3
    } state_t;

    // Index bit 0 clear picks the high nibble, so bytes replay high nibble first.
    function automatic logic [NIB_W-1:0] nib_sel(input logic [2*NIB_W-1:0] b, input logic lo);
        return lo ? b[NIB_W-1:0] : b[2*NIB_W-1:NIB_W];
    endfunction

endpackage

// File: rtl/luhn_nibble_buf.sv
// Byte-wide message buffer for the framer.
// Has one synchronous byte write port and one combinational nibble-indexed read port.
module luhn_nibble_buf
    import luhn_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic                clock,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [2*NIB_W-1:0]  i_wr_data,
    input  logic [AW:0]         i_rd_nib,
    output logic [NIB_W-1:0]    o_rd_data
);

    logic [2*NIB_W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = nib_sel(r_mem[i_rd_nib[AW:1]], i_rd_nib[0]);

endmodule

// File: rtl/luhn_nibble_framer.sv
// Buffers a byte-stream message, then offers its nibble count followed by its
// nibbles (high first) to the Luhn checker. Oversized messages are dropped.
module luhn_nibble_framer
    import luhn_pkg::*;
#(
    parameter int MAX_NIBBLES = 255
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              in_odd,
    output logic [SIZE_W-1:0] size,
    output logic              size_valid,
    input  logic              size_ready,
    output logic [NIB_W-1:0]  data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              ovf_err
);

    localparam int DEPTH = (MAX_NIBBLES + 1) / 2;
    localparam int AW    = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam logic [SIZE_W:0] MAX_W = (SIZE_W+1)'(MAX_NIBBLES);

    state_t            r_state;
    logic [SIZE_W-1:0] r_count;
    logic [SIZE_W-1:0] r_rd_idx;
    logic              r_ovf_err;

    logic [SIZE_W:0]   w_inc;
    logic [SIZE_W:0]   w_sum;
    logic              w_ovf;
    logic              w_wr_en;
    logic [NIB_W-1:0]  w_rd_nib;

    // Compare in 9 bits so a count near 255 can never wrap past the limit.
    assign w_inc   = (in_last && in_odd) ? (SIZE_W+1)'(1) : (SIZE_W+1)'(2);
    assign w_sum   = {1'b0, r_count} + w_inc;
    assign w_ovf   = (w_sum > MAX_W);
    assign w_wr_en = (r_state == FILL) && in_valid && !w_ovf;

    luhn_nibble_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_count[AW:1]),
        .i_wr_data (in_data),
        .i_rd_nib  (r_rd_idx[AW:0]),
        .o_rd_data (w_rd_nib)
    );

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_count   <= '0;
            r_rd_idx  <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            r_ovf_err <= 1'b0;
            case (r_state)
                FILL: begin
                    if (in_valid) begin
                        if (w_ovf) begin
                            r_ovf_err <= 1'b1;
                            r_count   <= '0;
                            if (!in_last) begin
                                r_state <= DRAIN;
                            end
                        end else begin
                            r_count <= w_sum[SIZE_W-1:0];
                            if (in_last) begin
                                r_state <= SEND_SIZE;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (in_valid && in_last) begin
                        r_state <= FILL;
                    end
                end
                SEND_SIZE: begin
                    if (size_ready) begin
                        r_rd_idx <= '0;
                        r_state  <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (data_ready) begin
                        r_rd_idx <= r_rd_idx + 1'b1;
                        if (r_rd_idx == r_count - 1'b1) begin
                            r_count <= '0;
                            r_state <= FILL;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready   = (r_state == FILL) || (r_state == DRAIN);
    assign size_valid = (r_state == SEND_SIZE);
    assign size       = size_valid ? r_count : '0;
    assign data_valid = (r_state == SEND_DATA);
    assign data       = data_valid ? w_rd_nib : '0;
    assign busy       = (r_state != FILL);
    assign ovf_err    = r_ovf_err;

endmodule

// File: tb/tb_luhn_nibble_framer.sv
// Directed bench for luhn_nibble_framer: a full-size instance and a MAX_NIBBLES=8
// instance share stimulus; sel routes handshakes and observation to one of them.
module tb_luhn_nibble_framer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_odd, size_ready, data_ready;
    logic       sel;

    logic       a_in_ready, a_size_valid, a_data_valid, a_busy, a_ovf;
    logic [7:0] a_size;
    logic [3:0] a_data;
    logic       b_in_ready, b_size_valid, b_data_valid, b_busy, b_ovf;
    logic [7:0] b_size;
    logic [3:0] b_data;

    logic a_in_valid, b_in_valid, a_size_ready, b_size_ready, a_data_ready, b_data_ready;
    assign a_in_valid   = in_valid & ~sel;
    assign b_in_valid   = in_valid & sel;
    assign a_size_ready = size_ready & ~sel;
    assign b_size_ready = size_ready & sel;
    assign a_data_ready = data_ready & ~sel;
    assign b_data_ready = data_ready & sel;

    logic       in_ready, size_valid, data_valid, busy, ovf_err;
    logic [7:0] size;
    logic [3:0] data;
    assign in_ready   = sel ? b_in_ready   : a_in_ready;
    assign size_valid = sel ? b_size_valid : a_size_valid;
    assign data_valid = sel ? b_data_valid : a_data_valid;
    assign busy       = sel ? b_busy       : a_busy;
    assign ovf_err    = sel ? b_ovf        : a_ovf;
    assign size       = sel ? b_size       : a_size;
    assign data       = sel ? b_data       : a_data;

    luhn_nibble_framer #(.MAX_NIBBLES(255)) u_dut_a (
        .clock(clock), .rst_n(rst_n), .in_data(in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_last(in_last), .in_odd(in_odd), .size(a_size),
        .size_valid(a_size_valid), .size_ready(a_size_ready), .data(a_data),
        .data_valid(a_data_valid), .data_ready(a_data_ready), .busy(a_busy), .ovf_err(a_ovf)
    );

    luhn_nibble_framer #(.MAX_NIBBLES(8)) u_dut_b (
        .clock(clock), .rst_n(rst_n), .in_data(in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_last(in_last), .in_odd(in_odd), .size(b_size),
        .size_valid(b_size_valid), .size_ready(b_size_ready), .data(b_data),
        .data_valid(b_data_valid), .data_ready(b_data_ready), .busy(b_busy), .ovf_err(b_ovf)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] msg [0:127];
    int         msg_len;
    bit         msg_odd;
    logic [3:0] exp_nib [0:255];
    int         exp_n;

    task automatic send_byte(input logic [7:0] b, input bit last, input bit odd, input int gap);
        int w;
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        in_data = b; in_last = last; in_odd = odd; in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clock);
            w++;
        end
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL in_ready_wait: in_ready=%b required 1 within 200 cycles", in_ready);
        else n_pass++;
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_last = 1'b0; in_odd = 1'b0;
    endtask

    // Sends msg[0..msg_len-1], builds the expected nibble list, checks size_valid latency.
    task automatic send_msg(input bit gaps, input string tag);
        for (int i = 0; i < msg_len; i++) begin
            exp_nib[2*i]   = msg[i][7:4];
            exp_nib[2*i+1] = msg[i][3:0];
            send_byte(msg[i], i == msg_len-1, msg_odd && (i == msg_len-1),
                      gaps ? int'($urandom_range(0, 7)) : 0);
        end
        exp_n = 2*msg_len - (msg_odd ? 1 : 0);
        @(negedge clock);
        n_checks++;
        if (size_valid !== 1'b1) $display("FAIL %s size_latency: size_valid=%b required 1", tag, size_valid);
        else n_pass++;
    endtask

    task automatic recv_size(input bit gaps, input string tag);
        int g;
        size_ready = 1'b0;
        if (gaps) begin
            g = $urandom_range(0, 7);
            for (int k = 0; k < g; k++) begin
                n_checks++;
                if (size_valid !== 1'b1 || size !== 8'(exp_n))
                    $display("FAIL %s size_hold: valid=%b size=%0d required 1/%0d", tag, size_valid, size, exp_n);
                else n_pass++;
                @(negedge clock);
            end
        end
        n_checks++;
        if (size_valid !== 1'b1 || size !== 8'(exp_n))
            $display("FAIL %s size: valid=%b size=%0d required 1/%0d", tag, size_valid, size, exp_n);
        else n_pass++;
        size_ready = 1'b1;
        @(posedge clock);
        #1;
        size_ready = 1'b0;
        @(negedge clock);
        n_checks++;
        if (size_valid !== 1'b0 || data_valid !== 1'b1)
            $display("FAIL %s size_to_data: size_valid=%b data_valid=%b required 0/1", tag, size_valid, data_valid);
        else n_pass++;
    endtask

    // Entered and left at a falling edge; without gaps data_ready stays high throughout.
    task automatic recv_data(input int n, input bit gaps, input string tag);
        int g;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                data_ready = 1'b0;
                g = $urandom_range(0, 7);
                for (int k = 0; k < g; k++) begin
                    n_checks++;
                    if (data_valid !== 1'b1 || data !== exp_nib[i])
                        $display("FAIL %s data_hold[%0d]: valid=%b data=%h required 1/%h", tag, i, data_valid, data, exp_nib[i]);
                    else n_pass++;
                    @(negedge clock);
                end
            end
            n_checks++;
            if (data_valid !== 1'b1 || data !== exp_nib[i])
                $display("FAIL %s data[%0d]: valid=%b data=%h required 1/%h", tag, i, data_valid, data, exp_nib[i]);
            else n_pass++;
            data_ready = 1'b1;
            @(posedge clock);
            #1;
            if (gaps) data_ready = 1'b0;
            @(negedge clock);
        end
        data_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (data_valid !== 1'b0 || size_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s idle: dv=%b sv=%b in_ready=%b busy=%b required 0/0/1/0", tag, data_valid, size_valid, in_ready, busy);
        else n_pass++;
    endtask

    task automatic check_reset_vals(input string tag);
        n_checks++;
        if ({in_ready, size_valid, data_valid, busy, ovf_err} !== 5'b10000 || size !== 8'd0 || data !== 4'd0)
            $display("FAIL %s reset_vals: rdy/sv/dv/busy/ovf=%b size=%0d data=%h required 10000/0/0",
                     tag, {in_ready, size_valid, data_valid, busy, ovf_err}, size, data);
        else n_pass++;
    endtask

    task automatic load_case1();
        logic [7:0] c1 [0:15];
        c1 = '{8'hFC, 8'hB5, 8'h6E, 8'h35, 8'hC4, 8'hDC, 8'hEE, 8'h98,
               8'hE6, 8'hC5, 8'hB3, 8'h88, 8'hBE, 8'h56, 8'h5C, 8'hD0};
        for (int i = 0; i < 16; i++) msg[i] = c1[i];
        msg_len = 16; msg_odd = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("reset_a");
        sel = 1'b1; #1;
        check_reset_vals("reset_b");
        sel = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_long_message();
        load_case1();
        send_msg(1'b0, "case1");
        n_checks++;
        if (exp_n != 31 || size !== 8'd31) $display("FAIL case1 size31: size=%0d required 31", size);
        else n_pass++;
        recv_size(1'b0, "case1");
        recv_data(exp_n, 1'b0, "case1");
        check_idle("case1");
    endtask

    task automatic test_short_even();
        msg[0] = 8'h12; msg[1] = 8'h34; msg_len = 2; msg_odd = 1'b0;
        send_msg(1'b0, "even");
        recv_size(1'b0, "even");
        recv_data(4, 1'b0, "even");
        check_idle("even");
    endtask

    task automatic test_single_nibble();
        msg[0] = 8'hA5; msg_len = 1; msg_odd = 1'b1;
        send_msg(1'b0, "single");
        recv_size(1'b0, "single");
        recv_data(1, 1'b0, "single");
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (data_valid !== 1'b0) $display("FAIL single extra_nibble: data_valid=%b data=%h required 0", data_valid, data);
            else n_pass++;
            @(negedge clock);
        end
        check_idle("single");
    endtask

    task automatic test_random_gaps();
        for (int m = 0; m < 4; m++) begin
            msg_len = $urandom_range(1, 10);
            msg_odd = 1'($urandom_range(0, 1));
            for (int i = 0; i < msg_len; i++) msg[i] = 8'($urandom);
            send_msg(1'b1, "random");
            recv_size(1'b1, "random");
            recv_data(exp_n, 1'b1, "random");
            check_idle("random");
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ob [0:4];
        ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_byte(ob[i], i == 4, 1'b0, 0);
            @(negedge clock);
            n_checks++;
            if (ovf_err !== (i == 4) || size_valid !== 1'b0)
                $display("FAIL ovf pulse[%0d]: ovf_err=%b size_valid=%b required %b/0", i, ovf_err, size_valid, i == 4);
            else n_pass++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            n_checks++;
            if (ovf_err !== 1'b0 || size_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL ovf after[%0d]: ovf_err=%b size_valid=%b busy=%b required 0/0/0", k, ovf_err, size_valid, busy);
            else n_pass++;
        end
        msg[0] = 8'h12; msg[1] = 8'h34; msg_len = 2; msg_odd = 1'b0;
        send_msg(1'b0, "post_ovf");
        recv_size(1'b0, "post_ovf");
        recv_data(4, 1'b0, "post_ovf");
        check_idle("post_ovf");
        sel = 1'b0;
    endtask

    task automatic test_drain();
        logic [7:0] db [0:5];
        db = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_byte(db[i], i == 5, 1'b0, 0);
            @(negedge clock);
            if (i == 4) begin
                n_checks++;
                if (ovf_err !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1)
                    $display("FAIL drain enter: ovf=%b busy=%b in_ready=%b required 1/1/1", ovf_err, busy, in_ready);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy !== 1'b0 || size_valid !== 1'b0 || ovf_err !== 1'b0)
            $display("FAIL drain exit: busy=%b size_valid=%b ovf=%b required 0/0/0", busy, size_valid, ovf_err);
        else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_exact_max();
        sel = 1'b1;
        msg[0] = 8'h9A; msg[1] = 8'hBC; msg[2] = 8'hDE; msg[3] = 8'hF0;
        msg_len = 4; msg_odd = 1'b0;
        send_msg(1'b0, "exact_max");
        n_checks++;
        if (ovf_err !== 1'b0 || size !== 8'd8) $display("FAIL exact_max accept: ovf=%b size=%0d required 0/8", ovf_err, size);
        else n_pass++;
        recv_size(1'b0, "exact_max");
        recv_data(8, 1'b0, "exact_max");
        check_idle("exact_max");
        sel = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit seen;
        load_case1();
        send_msg(1'b0, "abort");
        recv_size(1'b0, "abort");
        recv_data(3, 1'b0, "abort");
        data_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_reset_vals("abort");
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (size_valid !== 1'b0 || data_valid !== 1'b0) seen = 1'b1;
        end
        data_ready = 1'b0;
        n_checks++;
        if (seen) $display("FAIL abort residue: size/data valid seen=%b required 0", seen);
        else n_pass++;
        msg[0] = 8'h12; msg[1] = 8'h34; msg_len = 2; msg_odd = 1'b0;
        send_msg(1'b0, "after_abort");
        recv_size(1'b0, "after_abort");
        recv_data(4, 1'b0, "after_abort");
        check_idle("after_abort");
    endtask

    initial begin
        sel = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; in_odd = 1'b0;
        size_ready = 1'b0; data_ready = 1'b0; rst_n = 1'b0;
        test_reset();
        test_long_message();
        test_short_even();
        test_single_nibble();
        test_random_gaps();
        test_overflow();
        test_drain();
        test_exact_max();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
